// File: rtl/tl_pkg.sv
// tl_pkg: shared encodings for the timed two-street traffic-light controller.
//   - Light encodings L_GRN / L_YEL / L_RED (2'b11 is never driven).
//   - Controller state encodings S0..S3.
//   - lights_of(): Moore decode from state to the pair of street lights.
package tl_pkg;

  localparam logic [1:0] L_GRN = 2'b00;
  localparam logic [1:0] L_YEL = 2'b01;
  localparam logic [1:0] L_RED = 2'b10;

  // S0: A green / B red, S1: A yellow / B red,
  // S2: A red / B green, S3: A red / B yellow.
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } tl_state_e;

  typedef struct packed {
    logic [1:0] la;
    logic [1:0] lb;
  } tl_lights_t;

  // Every state keeps at least one street red, so the two streets can never
  // be green or yellow at the same time.
  function automatic tl_lights_t lights_of(input tl_state_e st);
    tl_lights_t l;
    l.la = L_RED;
    l.lb = L_RED;
    case (st)
      S0: begin
        l.la = L_GRN;
        l.lb = L_RED;
      end
      S1: begin
        l.la = L_YEL;
        l.lb = L_RED;
      end
      S2: begin
        l.la = L_RED;
        l.lb = L_GRN;
      end
      S3: begin
        l.la = L_RED;
        l.lb = L_YEL;
      end
      default: begin
        l.la = L_RED;
        l.lb = L_RED;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_phase_cnt.sv
// tl_phase_cnt: saturating phase counter for the traffic-light controller.
//   Counts cycles spent in the current controller state. Clears on clr,
//   otherwise increments by one and holds at all-ones (never wraps, so a
//   long green cannot alias back below the minimum-green threshold).
// Ports:
//   clk     - clock, rising-edge active
//   reset_n - synchronous active-low reset (cnt -> 0)
//   clr     - clear request; cnt is 0 in the following cycle
//   cnt     - current count, CNT_W bits
module tl_phase_cnt #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tl_cntr_timed.sv
// tl_cntr_timed: two-street traffic-light controller with minimum green,
// fixed yellow and (optionally) maximum green for fairness.
//
// Cycle: S0 (A green) -> S1 (A yellow) -> S2 (B green) -> S3 (B yellow) -> S0.
// A green phase ends once it has lasted MIN_GRN cycles and its own street's
// sensor is clear; a yellow phase lasts exactly YEL_CYC cycles.
//
// Optional feature, macro TL_MAXGRN_EN: a green phase also ends after MAX_GRN
// cycles if the other street is waiting, regardless of its own sensor. With
// the macro undefined MAX_GRN only takes part in the parameter sanity check.
//
// Ports:
//   clk     - clock, all state changes on its rising edge
//   reset_n - synchronous active-low reset: state S0, cnt 0, chg 0
//   Ta, Tb  - traffic present on street A / B (already synchronised)
//   La, Lb  - street A / B light (00 green, 01 yellow, 10 red)
//   chg     - registered pulse, high in the first cycle of every new state
module tl_cntr_timed
  import tl_pkg::*;
#(
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned MIN_GRN = 4,
  parameter int unsigned YEL_CYC = 3,
  parameter int unsigned MAX_GRN = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Ta,
  input  logic       Tb,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic       chg
);

  // Legal configuration: 1 <= YEL_CYC, 1 <= MIN_GRN <= MAX_GRN < 2^CNT_W.
  localparam bit PARAMS_OK = (YEL_CYC >= 1) && (MIN_GRN >= 1) && (MIN_GRN <= MAX_GRN) &&
                             (64'(MAX_GRN) < (64'd1 << CNT_W));

  // Count values of the last cycle of each timed phase.
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GRN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YEL_CYC - 1);
`ifdef TL_MAXGRN_EN
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GRN - 1);
`endif

  tl_state_e        state_d, state_q;
  logic             chg_d, chg_q;
  logic [CNT_W-1:0] cnt;
  logic             a_exit;     // leave A green this cycle
  logic             b_exit;     // leave B green this cycle
  logic             yel_done;   // last cycle of a yellow phase
  tl_lights_t       lights;

  // Phase counter restarts whenever the state is about to change, so cnt is
  // 0 in the first cycle of every state.
  tl_phase_cnt #(
    .CNT_W(CNT_W)
  ) u_phase_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (chg_d),
    .cnt    (cnt)
  );

  // Green-exit conditions. A sensor that drops early is simply held off by
  // the cnt threshold until the minimum green has been served.
  always_comb begin
    a_exit   = (cnt >= MIN_LAST) && !Ta;
    b_exit   = (cnt >= MIN_LAST) && !Tb;
    yel_done = (cnt == YEL_LAST);
`ifdef TL_MAXGRN_EN
    if ((cnt >= MAX_LAST) && Tb) begin
      a_exit = 1'b1;
    end
    if ((cnt >= MAX_LAST) && Ta) begin
      b_exit = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S0: if (a_exit)   state_d = S1;
      S1: if (yel_done) state_d = S2;
      S2: if (b_exit)   state_d = S3;
      S3: if (yel_done) state_d = S0;
      default:          state_d = S0;
    endcase
    chg_d = (state_d != state_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chg_q   <= chg_d;
    end
  end

  // Moore outputs: decoded from the state register only.
  always_comb begin
    lights = lights_of(state_q);
  end

  assign La  = lights.la;
  assign Lb  = lights.lb;
  assign chg = chg_q;

  // Simulation-only configuration check.
  param_legal_a : assert property (@(posedge clk) PARAMS_OK)
    else $error("tl_cntr_timed: illegal parameters CNT_W=%0d MIN_GRN=%0d YEL_CYC=%0d MAX_GRN=%0d",
                CNT_W, MIN_GRN, YEL_CYC, MAX_GRN);

endmodule

// File: tb/tb_tl_cntr_timed.sv
// Directed bench for tl_cntr_timed with default parameters. Each step pushes
// the expected lights/chg for the coming cycle into a scoreboard queue; after
// the clock edge the entry is popped and compared against the DUT.
module tb_tl_cntr_timed;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       Ta = 1'b0;
  logic       Tb = 1'b0;
  logic [1:0] La;
  logic [1:0] Lb;
  logic       chg;

  typedef struct {
    string      tag;
    logic [1:0] la;
    logic [1:0] lb;
    logic       chg;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [1:0] ela, elb;
  logic       ec;

  tl_cntr_timed dut (
    .clk    (clk),
    .reset_n(reset_n),
    .Ta     (Ta),
    .Tb     (Tb),
    .La     (La),
    .Lb     (Lb),
    .chg    (chg)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [1:0] la, input logic [1:0] lb,
                      input logic c);
    exp_t e;
    e.tag = tag;
    e.la  = la;
    e.lb  = lb;
    e.chg = c;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d entries required=1", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (La === e.la) else begin
        errors++;
        $error("FAIL %s La observed=%b expected=%b", e.tag, La, e.la);
      end
      checks++;
      assert (Lb === e.lb) else begin
        errors++;
        $error("FAIL %s Lb observed=%b expected=%b", e.tag, Lb, e.lb);
      end
      checks++;
      assert (chg === e.chg) else begin
        errors++;
        $error("FAIL %s chg observed=%b expected=%b", e.tag, chg, e.chg);
      end
      // Safety invariant: never 2'b11, never both streets non-red.
      checks++;
      assert ((La !== 2'b11) && (Lb !== 2'b11) && ((La === 2'b10) || (Lb === 2'b10))) else begin
        errors++;
        $error("FAIL %s safety observed La=%b Lb=%b expected one red and no 11",
               e.tag, La, Lb);
      end
    end
  endtask

  // Expect one more cycle: compared #1 after the next rising edge.
  task automatic cyc(input string tag, input logic [1:0] la, input logic [1:0] lb,
                     input logic c);
    push(tag, la, lb, c);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // Two reset edges, then release; returns in cycle 0 (cnt=0 of S0).
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    push({tag, "_rst"}, 2'b00, 2'b10, 1'b0);
    check_out();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    push({tag, "_c0"}, 2'b00, 2'b10, 1'b0);
    check_out();
  endtask

  // Free-running cycle with Ta=Tb=0: 4 green + 3 yellow per street, period 14.
  function automatic void free_exp(input int k, output logic [1:0] la, output logic [1:0] lb,
                                   output logic c);
    int p;
    p = k % 14;
    if (p < 4) begin
      la = 2'b00; lb = 2'b10;
    end else if (p < 7) begin
      la = 2'b01; lb = 2'b10;
    end else if (p < 11) begin
      la = 2'b10; lb = 2'b00;
    end else begin
      la = 2'b10; lb = 2'b01;
    end
    c = (k != 0) && (p == 0 || p == 4 || p == 7 || p == 11);
  endfunction

  initial begin
    // Free run, two full periods.
    Ta = 1'b0; Tb = 1'b0;
    do_reset("free");
    for (int k = 1; k <= 28; k++) begin
      free_exp(k, ela, elb, ec);
      cyc($sformatf("free_%0d", k), ela, elb, ec);
    end

    // Traffic on A only: A stays green, chg never fires.
    Ta = 1'b1; Tb = 1'b0;
    do_reset("hold_a");
    for (int k = 1; k <= 49; k++) begin
      cyc($sformatf("hold_a_%0d", k), 2'b00, 2'b10, 1'b0);
    end

    // Counter saturates at 31: dropping Ta at cycle 32 exits on the next edge.
    Ta = 1'b1; Tb = 1'b0;
    do_reset("sat");
    for (int k = 1; k <= 32; k++) begin
      cyc($sformatf("sat_%0d", k), 2'b00, 2'b10, 1'b0);
    end
    Ta = 1'b0;
    cyc("sat_exit", 2'b01, 2'b10, 1'b1);
    cyc("sat_yel1", 2'b01, 2'b10, 1'b0);
    cyc("sat_yel2", 2'b01, 2'b10, 1'b0);
    cyc("sat_bgrn", 2'b10, 2'b00, 1'b1);

    // Early sensor drop at cnt=1 is held until minimum green is served.
    Ta = 1'b1; Tb = 1'b0;
    do_reset("early");
    cyc("early_1", 2'b00, 2'b10, 1'b0);
    Ta = 1'b0;
    cyc("early_2", 2'b00, 2'b10, 1'b0);
    cyc("early_3", 2'b00, 2'b10, 1'b0);
    cyc("early_4", 2'b01, 2'b10, 1'b1);
    cyc("early_5", 2'b01, 2'b10, 1'b0);
    cyc("early_6", 2'b01, 2'b10, 1'b0);
    cyc("early_7", 2'b10, 2'b00, 1'b1);

    // Traffic on B holds S2 until Tb drops.
    Ta = 1'b0; Tb = 1'b1;
    do_reset("hold_b");
    for (int k = 1; k <= 20; k++) begin
      free_exp(k, ela, elb, ec);
      if (k >= 11) begin
        ela = 2'b10; elb = 2'b00; ec = 1'b0;
      end
      cyc($sformatf("hold_b_%0d", k), ela, elb, ec);
    end
    Tb = 1'b0;
    cyc("hold_b_21", 2'b10, 2'b01, 1'b1);
    cyc("hold_b_22", 2'b10, 2'b01, 1'b0);
    cyc("hold_b_23", 2'b10, 2'b01, 1'b0);
    cyc("hold_b_24", 2'b00, 2'b10, 1'b1);

    // Reset for one edge in S3 at cnt=1 (cycle 12), then a glitch between edges.
    Ta = 1'b0; Tb = 1'b0;
    do_reset("rst_s3");
    for (int k = 1; k <= 12; k++) begin
      free_exp(k, ela, elb, ec);
      cyc($sformatf("pre_s3_%0d", k), ela, elb, ec);
    end
    reset_n = 1'b0;
    cyc("rst_s3_hit", 2'b00, 2'b10, 1'b0);
    reset_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      free_exp(k, ela, elb, ec);
      cyc($sformatf("post_rst_%0d", k), ela, elb, ec);
      if (k == 5) begin
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
    end

`ifdef TL_MAXGRN_EN
    // Both streets busy: each green is cut at MAX_GRN=16 cycles.
    Ta = 1'b1; Tb = 1'b1;
    do_reset("maxg");
    for (int k = 1; k <= 15; k++) begin
      cyc($sformatf("maxg_a_%0d", k), 2'b00, 2'b10, 1'b0);
    end
    cyc("maxg_ayel0", 2'b01, 2'b10, 1'b1);
    cyc("maxg_ayel1", 2'b01, 2'b10, 1'b0);
    cyc("maxg_ayel2", 2'b01, 2'b10, 1'b0);
    cyc("maxg_b_0", 2'b10, 2'b00, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      cyc($sformatf("maxg_b_%0d", k), 2'b10, 2'b00, 1'b0);
    end
    cyc("maxg_byel0", 2'b10, 2'b01, 1'b1);
    cyc("maxg_byel1", 2'b10, 2'b01, 1'b0);
    cyc("maxg_byel2", 2'b10, 2'b01, 1'b0);
    cyc("maxg_a_again", 2'b00, 2'b10, 1'b1);
`else
    // Both streets busy without fairness: A keeps green indefinitely.
    Ta = 1'b1; Tb = 1'b1;
    do_reset("nomax");
    for (int k = 1; k <= 40; k++) begin
      cyc($sformatf("nomax_%0d", k), 2'b00, 2'b10, 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
